// File: rtl/prio_encoder_rr.sv
// Purpose : N-to-log2(N) request encoder, fixed-priority or round-robin, registered result.
// Latency : result is registered one cycle after req is sampled; one result per cycle with out_ready high.
// Backpr. : a held result stays frozen while out_ready is low; req is ignored (not latched) during a stall.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, dominates all other inputs
//   req        N level-sensitive request lines, bit i = source i
//   out_ready  consumer accepts the current result this cycle
//   out_valid  out_idx / out_onehot / out_multi carry a valid result
//   out_idx    binary index of the winning request line (always < N)
//   out_onehot one-hot form of out_idx
//   out_multi  more than one request was set when the result was captured
module prio_encoder_rr #(
    parameter int N    = 8,
    parameter int MODE = 0,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_multi
);

    // Index of the lowest set bit of v; 0 when v is empty (callers guard on |v).
    function automatic logic [W-1:0] lowest_set(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = W'(i);
            end
        end
        return r;
    endfunction

    // Round-robin pointer: index that has highest priority on the next capture.
    // Held at 0 in fixed-priority mode.
    logic [W-1:0] ptr;

    logic         load;
    logic         any_req;
    logic [N-1:0] above_mask;
    logic [N-1:0] req_hi;
    logic [W-1:0] win_idx;
    logic [N-1:0] win_onehot;
    logic         win_multi;
    logic [W-1:0] ptr_nxt;

    // The output register can take a new value when empty or when its current
    // content is being consumed this very cycle.
    assign load    = !out_valid || out_ready;
    assign any_req = |req;

    // Requests at or above the pointer are scanned first; if none exist the
    // search wraps and the lowest request overall wins. This implements the
    // circular scan without a rotator, and is independent of N being a power of 2.
    always_comb begin
        above_mask = '0;
        for (int i = 0; i < N; i++) begin
            above_mask[i] = (W'(i) >= ptr);
        end
    end

    assign req_hi = req & above_mask;

    always_comb begin
        win_idx = '0;
        if (MODE != 0 && (|req_hi)) begin
            win_idx = lowest_set(req_hi);
        end else begin
            win_idx = lowest_set(req);
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < N; i++) begin
            win_onehot[i] = (win_idx == W'(i));
        end
    end

    // Clearing the lowest set bit leaves something behind only if two or more bits were set.
    assign win_multi = |(req & (req - {{(N-1){1'b0}}, 1'b1}));

    // Explicit wrap rather than a modulo so non-power-of-2 N never yields ptr >= N.
    assign ptr_nxt = (win_idx == W'(N - 1)) ? '0 : (win_idx + W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            out_multi  <= 1'b0;
            ptr        <= '0;
        end else if (load) begin
            if (any_req) begin
                out_valid  <= 1'b1;
                out_idx    <= win_idx;
                out_onehot <= win_onehot;
                out_multi  <= win_multi;
                if (MODE != 0) begin
                    ptr <= ptr_nxt;
                end
            end else begin
                // Data fields keep their last value; only valid drops.
                out_valid <= 1'b0;
            end
        end
    end

    // Structural invariants of the output register and pointer.
    a_idx_range: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (int'(out_idx) < N));

    a_onehot_match: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> (out_onehot == (N'(1) << out_idx)));

    a_ptr_range: assert property (@(posedge clk) disable iff (rst)
        int'(ptr) < N);

    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_idx) && $stable(out_onehot) && $stable(out_multi)));

endmodule

// File: tb/tb_prio_encoder_rr.sv
module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req0 = '0;
    logic [7:0] req1 = '0;
    logic [4:0] req2 = '0;
    logic [2:0] rdy  = '1;

    logic       v0, v1, v2;
    logic [2:0] idx0, idx1, idx2;
    logic [7:0] oh0, oh1;
    logic [4:0] oh2;
    logic       m0, m1, m2;

    int n_checks = 0;
    int n_fail   = 0;

    // dut 0: N=8 fixed, dut 1: N=8 round-robin, dut 2: N=5 round-robin
    int nn [3] = '{8, 8, 5};
    int md [3] = '{0, 1, 1};

    // reference model state: valid, index, multi, round-robin pointer
    bit mv [3];
    int mi [3];
    bit mm [3];
    int mp [3];

    always #5 clk = ~clk;

    prio_encoder_rr #(.N(8), .MODE(0)) u_fix8 (
        .clk(clk), .rst(rst), .req(req0), .out_ready(rdy[0]),
        .out_valid(v0), .out_idx(idx0), .out_onehot(oh0), .out_multi(m0));

    prio_encoder_rr #(.N(8), .MODE(1)) u_rr8 (
        .clk(clk), .rst(rst), .req(req1), .out_ready(rdy[1]),
        .out_valid(v1), .out_idx(idx1), .out_onehot(oh1), .out_multi(m1));

    prio_encoder_rr #(.N(5), .MODE(1)) u_rr5 (
        .clk(clk), .rst(rst), .req(req2), .out_ready(rdy[2]),
        .out_valid(v2), .out_idx(idx2), .out_onehot(oh2), .out_multi(m2));

    typedef struct {
        logic       rs;
        int         dut;
        logic [7:0] rq;
        logic       rd;
        logic       ev;
        logic [2:0] ei;
        logic [7:0] eoh;
        logic       em;
        logic       chk_data;
        int         tno;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rs, input int d, input logic [7:0] rq, input logic rd,
                                input logic ev, input logic [2:0] ei, input logic [7:0] eoh,
                                input logic em, input logic cd, input int t);
        vec_t e;
        e.rs = rs; e.dut = d; e.rq = rq; e.rd = rd; e.ev = ev; e.ei = ei;
        e.eoh = eoh; e.em = em; e.chk_data = cd; e.tno = t;
        tbl.push_back(e);
    endfunction

    function automatic logic [7:0] get_req(input int d);
        case (d)
            0:       return req0;
            1:       return req1;
            default: return {3'b000, req2};
        endcase
    endfunction

    task automatic set_in(input int d, input logic [7:0] r, input logic rd);
        case (d)
            0:       req0 = r;
            1:       req1 = r;
            default: req2 = r[4:0];
        endcase
        rdy[d] = rd;
    endtask

    task automatic get_out(input int d, output logic v, output logic [2:0] ix,
                           output logic [7:0] oh, output logic m);
        case (d)
            0:       begin v = v0; ix = idx0; oh = oh0;           m = m0; end
            1:       begin v = v1; ix = idx1; oh = oh1;           m = m1; end
            default: begin v = v2; ix = idx2; oh = {3'b000, oh2}; m = m2; end
        endcase
    endtask

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // Circular scan over the request lines starting at the pointer.
    function automatic int ref_winner(input int d, input logic [7:0] r);
        int start;
        start = (md[d] != 0) ? mp[d] : 0;
        for (int k = 0; k < nn[d]; k++) begin
            int j;
            j = (start + k) % nn[d];
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input int d, input logic [7:0] r, input logic rd, input logic rs);
        int w;
        if (rs) begin
            mv[d] = 0; mi[d] = 0; mm[d] = 0; mp[d] = 0;
        end else if (!mv[d] || rd) begin
            w = ref_winner(d, r);
            if (w >= 0) begin
                mv[d] = 1;
                mi[d] = w;
                mm[d] = ($countones(r) > 1);
                if (md[d] != 0) mp[d] = (w + 1) % nn[d];
            end else begin
                mv[d] = 0;
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare every DUT against it shortly after the edge.
    task automatic tick();
        logic       v, m;
        logic [2:0] ix;
        logic [7:0] oh;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            model_step(d, get_req(d), rdy[d], rst);
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            get_out(d, v, ix, oh, m);
            check("model_valid", d, {31'b0, v}, {31'b0, mv[d]});
            check("idx_range", d, {31'b0, (int'(ix) < nn[d])}, 32'd1);
            if (mv[d]) begin
                check("model_idx", d, {29'b0, ix}, mi[d]);
                check("model_onehot", d, {24'b0, oh}, 32'd1 << mi[d]);
                check("model_multi", d, {31'b0, m}, {31'b0, mm[d]});
            end
        end
    endtask

    initial begin
        logic       v, m;
        logic [2:0] ix;
        logic [7:0] oh;
        logic [7:0] r;

        // Reset held two cycles with all requests asserted.
        rst = 1'b1;
        req0 = 8'hFF; req1 = 8'hFF; req2 = 5'h1F; rdy = 3'b111;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            get_out(d, v, ix, oh, m);
            check("rst_valid", d, {31'b0, v}, 32'd0);
            check("rst_idx", d, {29'b0, ix}, 32'd0);
            check("rst_onehot", d, {24'b0, oh}, 32'd0);
            check("rst_multi", d, {31'b0, m}, 32'd0);
        end
        rst = 1'b0;
        tick();
        get_out(1, v, ix, oh, m);
        check("first_rr_valid", 1, {31'b0, v}, 32'd1);
        check("first_rr_idx", 1, {29'b0, ix}, 32'd0);

        // Fixed priority
        add(0, 0, 8'hA4, 1, 1, 3'd2, 8'h04, 1, 1, 2);
        add(0, 0, 8'h80, 1, 1, 3'd7, 8'h80, 0, 1, 2);
        add(0, 0, 8'h00, 1, 0, 3'd0, 8'h00, 0, 0, 2);
        // Stall: frozen at idx 2 while req moves to bit 7
        add(0, 0, 8'h24, 1, 1, 3'd2, 8'h04, 1, 1, 3);
        for (int k = 0; k < 4; k++) add(0, 0, 8'h80, 0, 1, 3'd2, 8'h04, 1, 1, 3);
        add(0, 0, 8'h80, 1, 1, 3'd7, 8'h80, 0, 1, 3);
        add(0, 0, 8'h00, 1, 0, 3'd0, 8'h00, 0, 0, 3);
        // Round-robin N=8
        add(1, 1, 8'hFF, 1, 0, 3'd0, 8'h00, 0, 1, 4);
        for (int k = 0; k < 11; k++) begin
            logic [7:0] o;
            o = 8'd1 << (k % 8);
            add(0, 1, 8'hFF, 1, 1, 3'(k % 8), o, 1, 1, 4);
        end
        add(0, 1, 8'h11, 1, 1, 3'd4, 8'h10, 1, 1, 4);
        add(0, 1, 8'h11, 1, 1, 3'd0, 8'h01, 1, 1, 4);
        // Round-robin N=5 wrap
        add(1, 2, 8'h1F, 1, 0, 3'd0, 8'h00, 0, 1, 5);
        add(0, 2, 8'h10, 1, 1, 3'd4, 8'h10, 0, 1, 5);
        add(0, 2, 8'h11, 1, 1, 3'd0, 8'h01, 1, 1, 5);
        add(0, 2, 8'h11, 1, 1, 3'd4, 8'h10, 1, 1, 5);
        for (int k = 0; k < 6; k++) begin
            logic [7:0] o;
            o = 8'd1 << (k % 5);
            add(0, 2, 8'h1F, 1, 1, 3'(k % 5), o, 1, 1, 5);
        end
        // Reset during a stall with ptr=3
        add(1, 1, 8'hFF, 1, 0, 3'd0, 8'h00, 0, 1, 6);
        add(0, 1, 8'hFF, 1, 1, 3'd0, 8'h01, 1, 1, 6);
        add(0, 1, 8'hFF, 1, 1, 3'd1, 8'h02, 1, 1, 6);
        add(0, 1, 8'hFF, 1, 1, 3'd2, 8'h04, 1, 1, 6);
        add(0, 1, 8'hFF, 0, 1, 3'd2, 8'h04, 1, 1, 6);
        add(1, 1, 8'hFF, 0, 0, 3'd0, 8'h00, 0, 1, 6);
        add(0, 1, 8'hFF, 1, 1, 3'd0, 8'h01, 1, 1, 6);

        foreach (tbl[i]) begin
            rst = tbl[i].rs;
            for (int d = 0; d < 3; d++) set_in(d, 8'h00, 1'b1);
            set_in(tbl[i].dut, tbl[i].rq, tbl[i].rd);
            tick();
            get_out(tbl[i].dut, v, ix, oh, m);
            check($sformatf("vec%0d_t%0d_valid", i, tbl[i].tno), tbl[i].dut, {31'b0, v}, {31'b0, tbl[i].ev});
            if (tbl[i].chk_data) begin
                check($sformatf("vec%0d_t%0d_idx", i, tbl[i].tno), tbl[i].dut, {29'b0, ix}, {29'b0, tbl[i].ei});
                check($sformatf("vec%0d_t%0d_onehot", i, tbl[i].tno), tbl[i].dut, {24'b0, oh}, {24'b0, tbl[i].eoh});
                check($sformatf("vec%0d_t%0d_multi", i, tbl[i].tno), tbl[i].dut, {31'b0, m}, {31'b0, tbl[i].em});
            end
        end
        rst = 1'b0;

        // Randomised traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int d = 0; d < 3; d++) begin
                r = 8'($urandom);
                case ($urandom_range(0, 3))
                    0:       r = 8'h00;
                    1:       r = r & 8'($urandom) & 8'($urandom);
                    2:       r = 8'd1 << $urandom_range(0, 7);
                    default: r = r;
                endcase
                set_in(d, r, ($urandom_range(0, 9) < 7));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
